spawn_scheduler: RTL and testbench

Sequences the asteroid slots of the play field: decides when a new asteroid launches, which free slot receives it, its starting x column, and the current fall speed. Sits between the frame-rate timing logic and the bank of asteroid slot datapaths, replacing free-running spawn and speed dividers with a slot-aware allocator and a difficulty ramp. Runs in the pixel clock domain. All frame-rate activity is qualified by a one-cycle `frame_tick`.

---
 rtl/spawn_pkg.sv | 26 ++
 rtl/slot_alloc.sv | 23 ++
 rtl/spawn_scheduler.sv | 168 ++++++++++++++++
 tb/tb_spawn_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spawn_pkg.sv
// rtl/spawn_pkg.sv - shared types, defaults and x-column wrap helper for spawn_scheduler
package spawn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_PICK,
        S_ISSUE,
        S_FROZEN
    } spawn_state_t;

    localparam int DEF_NSLOT         = 7;
    localparam int DEF_BASE_INTERVAL = 128;
    localparam int DEF_INTERVAL_STEP = 24;
    localparam int DEF_MIN_INTERVAL  = 32;
    localparam int DEF_LEVEL_SPAWNS  = 8;
    localparam int DEF_MAX_LEVEL     = 3;
    localparam int X_RANGE           = 611;
    localparam int SLOT_W            = $clog2(DEF_NSLOT);

    // rng spans 0..1023 and range is above 512, so one subtract always lands in range
    function automatic logic [9:0] wrap_x(input logic [9:0] r, input logic [9:0] range);
        return (r < range) ? r : r - range;
    endfunction

endpackage

// File: rtl/slot_alloc.sv
// rtl/slot_alloc.sv - lowest-index free slot priority encoder
module slot_alloc
    import spawn_pkg::*;
#(
    parameter int NSLOT = DEF_NSLOT
) (
    input  logic [NSLOT-1:0]  slot_active,
    output logic [SLOT_W-1:0] free_idx,
    output logic              any_free
);

    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!slot_active[i]) begin
                free_idx = SLOT_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spawn_scheduler.sv
// rtl/spawn_scheduler.sv - asteroid spawn allocator with difficulty ramp (SPAWN_LEVEL_RAMP_EN)
module spawn_scheduler
    import spawn_pkg::*;
#(
    parameter int NSLOT         = DEF_NSLOT,
    parameter int BASE_INTERVAL = DEF_BASE_INTERVAL,
    parameter int INTERVAL_STEP = DEF_INTERVAL_STEP,
    parameter int MIN_INTERVAL  = DEF_MIN_INTERVAL,
    parameter int LEVEL_SPAWNS  = DEF_LEVEL_SPAWNS,
    parameter int MAX_LEVEL     = DEF_MAX_LEVEL,
    parameter int X_RANGE       = spawn_pkg::X_RANGE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              frame_tick,
    input  logic              game_over,
    input  logic [9:0]        rng,
    input  logic [NSLOT-1:0]  slot_done,
    input  logic              spawn_ready,
    output logic              spawn_valid,
    output logic [SLOT_W-1:0] spawn_slot,
    output logic [9:0]        spawn_x,
    output logic [NSLOT-1:0]  slot_active,
    output logic [2:0]        speed,
    output logic [1:0]        level
);

    localparam int         CNT_W = $clog2(BASE_INTERVAL + 1);
    localparam logic [9:0] X_LIM = 10'(X_RANGE);

    if (MAX_LEVEL > 3 || LEVEL_SPAWNS < 1 || INTERVAL_STEP < 0 ||
        MIN_INTERVAL < 1 || BASE_INTERVAL < MIN_INTERVAL) begin : g_bad_cfg
        $error("spawn_scheduler: unsupported parameter set");
    end

    spawn_state_t      state_q, state_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic              spawn_valid_q, spawn_valid_d;
    logic [SLOT_W-1:0] spawn_slot_q, spawn_slot_d;
    logic [9:0]        spawn_x_q, spawn_x_d;
    logic [NSLOT-1:0]  slot_active_q, slot_active_d;
    logic [CNT_W-1:0]  interval_m1;
    logic [SLOT_W-1:0] free_idx;
    logic              any_free;

    slot_alloc #(.NSLOT(NSLOT)) u_slot_alloc (
        .slot_active (slot_active_q),
        .free_idx    (free_idx),
        .any_free    (any_free)
    );

`ifdef SPAWN_LEVEL_RAMP_EN
    localparam int LVL_W = $clog2(LEVEL_SPAWNS + 1);

    logic [1:0]       level_q, level_d;
    logic [2:0]       speed_q, speed_d;
    logic [LVL_W-1:0] lvl_cnt_q, lvl_cnt_d;
    int               interval;

    always_comb begin
        interval = BASE_INTERVAL - int'(level_q) * INTERVAL_STEP;
        if (interval < MIN_INTERVAL) interval = MIN_INTERVAL;
        interval_m1 = CNT_W'(interval - 1);
    end

    assign level = level_q;
    assign speed = speed_q;
`else
    assign interval_m1 = CNT_W'(BASE_INTERVAL - 1);
    assign level       = 2'd0;
    assign speed       = 3'd1;
`endif

    always_comb begin
        state_d       = state_q;
        frame_cnt_d   = frame_cnt_q;
        spawn_valid_d = spawn_valid_q;
        spawn_slot_d  = spawn_slot_q;
        spawn_x_d     = spawn_x_q;
        slot_active_d = slot_active_q;
`ifdef SPAWN_LEVEL_RAMP_EN
        level_d       = level_q;
        speed_d       = speed_q;
        lvl_cnt_d     = lvl_cnt_q;
`endif
        if (state_q != S_FROZEN) slot_active_d = slot_active_q & ~slot_done;

        // game_over outranks any pending accept: the offer is withdrawn, not completed
        if (game_over && state_q != S_IDLE) begin
            state_d       = S_FROZEN;
            spawn_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    state_d     = S_WAIT;
                    frame_cnt_d = '0;
                end
                S_WAIT: if (frame_tick) begin
                    if (frame_cnt_q == interval_m1) begin
                        frame_cnt_d = '0;
                        state_d     = S_PICK;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
                S_PICK: if (any_free) begin
                    spawn_slot_d  = free_idx;
                    spawn_x_d     = wrap_x(rng, X_LIM);
                    spawn_valid_d = 1'b1;
                    state_d       = S_ISSUE;
                end
                S_ISSUE: if (spawn_ready) begin
                    spawn_valid_d               = 1'b0;
                    slot_active_d[spawn_slot_q] = 1'b1;
                    frame_cnt_d                 = '0;
                    state_d                     = S_WAIT;
`ifdef SPAWN_LEVEL_RAMP_EN
                    if (lvl_cnt_q == LVL_W'(LEVEL_SPAWNS - 1)) begin
                        lvl_cnt_d = '0;
                        if (level_q != 2'(MAX_LEVEL)) begin
                            level_d = level_q + 1'b1;
                            speed_d = speed_q + 1'b1;
                        end
                    end else begin
                        lvl_cnt_d = lvl_cnt_q + 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            frame_cnt_q   <= '0;
            spawn_valid_q <= 1'b0;
            spawn_slot_q  <= '0;
            spawn_x_q     <= '0;
            slot_active_q <= '0;
`ifdef SPAWN_LEVEL_RAMP_EN
            level_q       <= 2'd0;
            speed_q       <= 3'd1;
            lvl_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            spawn_valid_q <= spawn_valid_d;
            spawn_slot_q  <= spawn_slot_d;
            spawn_x_q     <= spawn_x_d;
            slot_active_q <= slot_active_d;
`ifdef SPAWN_LEVEL_RAMP_EN
            level_q       <= level_d;
            speed_q       <= speed_d;
            lvl_cnt_q     <= lvl_cnt_d;
`endif
        end
    end

    assign spawn_valid = spawn_valid_q;
    assign spawn_slot  = spawn_slot_q;
    assign spawn_x     = spawn_x_q;
    assign slot_active = slot_active_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// tb/tb_spawn_scheduler.sv - self-checking bench for spawn_scheduler
module tb_spawn_scheduler;

`ifdef SPAWN_LEVEL_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    logic       clk, reset_n, start, frame_tick, game_over, spawn_ready;
    logic [9:0] rng;
    logic [6:0] slot_done;
    logic       spawn_valid;
    logic [2:0] spawn_slot;
    logic [9:0] spawn_x;
    logic [6:0] slot_active;
    logic [2:0] speed;
    logic [1:0] level;

    spawn_scheduler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .frame_tick  (frame_tick),
        .game_over   (game_over),
        .rng         (rng),
        .slot_done   (slot_done),
        .spawn_ready (spawn_ready),
        .spawn_valid (spawn_valid),
        .spawn_slot  (spawn_slot),
        .spawn_x     (spawn_x),
        .slot_active (slot_active),
        .speed       (speed),
        .level       (level)
    );

    typedef struct packed {
        logic [2:0] slot;
        logic [9:0] x;
    } exp_t;

    typedef struct {
        logic [9:0] rng;
        logic [9:0] exp_x;
        logic [2:0] exp_slot;
    } vec_t;

    exp_t sb_q[$];
    exp_t sb_e;
    vec_t vecs[5];
    int   checks = 0;
    int   passes = 0;
    int   acc;
    int   n;
    int   exp_lvl;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic tick_n(input int cnt);
        repeat (cnt) tick();
    endtask

    task automatic tick_until_valid(output int ticks);
        ticks = 0;
        while (!spawn_valid && ticks < 300) begin
            tick();
            ticks++;
        end
    endtask

    function automatic int model_level(input int accepted);
        int l;
        l = RAMP ? accepted / 8 : 0;
        return (l > 3) ? 3 : l;
    endfunction

    function automatic int model_interval(input int lvl);
        int iv;
        iv = 128 - 24 * lvl;
        return (iv < 32) ? 32 : iv;
    endfunction

    always @(negedge clk) begin
        if (reset_n && spawn_valid && spawn_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_accept", 1, 0);
            end else begin
                sb_e = sb_q.pop_front();
                check("sb_slot", int'(spawn_slot), int'(sb_e.slot));
                check("sb_x", int'(spawn_x), int'(sb_e.x));
            end
        end
    end

    initial begin
        vecs[0] = '{rng: 10'd610,  exp_x: 10'd610, exp_slot: 3'd2};
        vecs[1] = '{rng: 10'd611,  exp_x: 10'd0,   exp_slot: 3'd3};
        vecs[2] = '{rng: 10'd1023, exp_x: 10'd412, exp_slot: 3'd4};
        vecs[3] = '{rng: 10'd0,    exp_x: 10'd0,   exp_slot: 3'd5};
        vecs[4] = '{rng: 10'd89,   exp_x: 10'd89,  exp_slot: 3'd6};

        reset_n = 1'b0; start = 1'b0; frame_tick = 1'b0; game_over = 1'b0;
        spawn_ready = 1'b0; rng = '0; slot_done = '0;
        repeat (3) step();
        check("rst_valid", spawn_valid, 0);
        check("rst_slot", spawn_slot, 0);
        check("rst_x", spawn_x, 0);
        check("rst_active", slot_active, 0);
        check("rst_level", level, 0);
        check("rst_speed", speed, 1);
        reset_n = 1'b1;
        step();

        // first spawn: latency after tick 128, x wrap of 700
        spawn_ready = 1'b1;
        rng = 10'd700;
        start = 1'b1;
        step();
        start = 1'b0;
        sb_q.push_back('{slot: 3'd0, x: 10'd89});
        tick_n(127);
        check("t1_early", spawn_valid, 0);
        tick();
        check("t1_valid", spawn_valid, 1);
        check("t1_slot", spawn_slot, 0);
        check("t1_x", spawn_x, 89);
        step();
        check("t1_active", slot_active, 7'b0000001);
        check("t1_drop", spawn_valid, 0);

        // back-pressure hold
        spawn_ready = 1'b0;
        rng = 10'd5;
        sb_q.push_back('{slot: 3'd1, x: 10'd5});
        tick_n(128);
        check("t2_valid", spawn_valid, 1);
        for (int c = 0; c < 10; c++) begin
            rng = 10'($urandom_range(0, 1023));
            frame_tick = c[0];
            step();
            check("t2_hold", int'({spawn_valid, spawn_slot, spawn_x}), int'({1'b1, 3'd1, 10'd5}));
            check("t2_no_accept", slot_active, 7'b0000001);
        end
        frame_tick = 1'b0;
        spawn_ready = 1'b1;
        step();
        check("t2_active", slot_active, 7'b0000011);
        check("t2_drop", spawn_valid, 0);

        // x boundary table filling slots 2..6
        for (int v = 0; v < 5; v++) begin
            rng = vecs[v].rng;
            sb_q.push_back('{slot: vecs[v].exp_slot, x: vecs[v].exp_x});
            tick_n(128);
            check("tbl_valid", spawn_valid, 1);
            check("tbl_x", spawn_x, vecs[v].exp_x);
            check("tbl_slot", spawn_slot, vecs[v].exp_slot);
            step();
            check("tbl_active", slot_active[vecs[v].exp_slot], 1);
        end
        check("tbl_full", slot_active, 7'h7F);

        // all slots busy: PICK stalls until slot 4 frees
        rng = 10'd100;
        tick_n(128);
        check("st_stall", spawn_valid, 0);
        repeat (4) step();
        check("st_stall2", spawn_valid, 0);
        sb_q.push_back('{slot: 3'd4, x: 10'd100});
        slot_done = 7'h10;
        step();
        slot_done = '0;
        check("st_cleared", slot_active, 7'h6F);
        check("st_not_yet", spawn_valid, 0);
        step();
        check("st_valid", spawn_valid, 1);
        check("st_slot", spawn_slot, 4);
        step();
        check("st_refill", slot_active, 7'h7F);
        acc = 8;
        check("lv8_level", level, model_level(acc));
        check("lv8_speed", speed, model_level(acc) + 1);

        // level ramp and saturation
        rng = 10'd300;
        for (int k = 0; k < 18; k++) begin
            slot_done = 7'h7F;
            step();
            slot_done = '0;
            exp_lvl = model_level(acc);
            sb_q.push_back('{slot: 3'd0, x: 10'd300});
            tick_until_valid(n);
            check("ramp_interval", n, model_interval(exp_lvl));
            check("ramp_slot", spawn_slot, 0);
            step();
            acc++;
            check("ramp_level", level, model_level(acc));
            check("ramp_speed", speed, model_level(acc) + 1);
        end

        // game_over mid-handshake freezes everything
        spawn_ready = 1'b0;
        tick_until_valid(n);
        check("go_interval", n, model_interval(model_level(acc)));
        check("go_slot", spawn_slot, 1);
        game_over = 1'b1;
        step();
        check("go_drop", spawn_valid, 0);
        slot_done = 7'h7F;
        spawn_ready = 1'b1;
        step();
        slot_done = '0;
        check("go_active_hold", slot_active, 7'b0000001);
        tick_n(150);
        check("go_no_spawn", spawn_valid, 0);
        check("go_active_hold2", slot_active, 7'b0000001);
        check("go_level", level, model_level(acc));
        check("go_speed", speed, model_level(acc) + 1);
        check("sb_empty", sb_q.size(), 0);

        // asynchronous reset without a clock edge
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("ar_active", slot_active, 0);
        check("ar_level", level, 0);
        check("ar_speed", speed, 1);
        check("ar_valid", spawn_valid, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
